sd_block_reader: RTL and testbench
==================================

// Module: sd_block_reader
// PURPOSE
//  Host-side consumer of the SD card controller's read path. Issues single-block
//  READ requests (execute/op_code/block_address), captures the 512 data bytes it
//  streams out into an internal byte RAM, checks the trailing CRC16, and exposes
//  the block to the host through a synchronous random-access read port.
// PARAMETERS
//  BLOCK_BYTES    512       data bytes per block (power of two)
//  TIMEOUT_CYCLES 2000000   clk cycles allowed from issue to block done
//  CRC_CHECK      1         1: compare trailing CRC16; 0: discard the 2 CRC bytes
// PORTS
//  clk             in   1   master clock, posedge
//  rst             in   1   asynchronous reset, active-high
//  req             in   1   1-cycle pulse: read block req_addr (ignored unless ready)
//  req_addr        in   32  block address to read
//  ready           out  1   idle, accepting req
//  done            out  1   1-cycle pulse: block captured (check crc_ok/timeout_err)
//  crc_ok          out  1   last block's CRC matched (held until next req)
//  timeout_err     out  1   last request timed out (held until next req)
//  rd_addr         in   9   host byte index into captured block
//  rd_data         out  8   RAM[rd_addr], registered, 1-cycle latency
//  ctrl_execute    out  1   to controller execute
//  ctrl_op_code    out  1   to controller op_code, constant 1'b0 (READ)
//  ctrl_block_addr out  32  to controller block_address, latched at req
//  ctrl_busy       in   1   controller busy
//  ctrl_byte_valid in   1   controller finished_byte (level; new byte on 0->1)
//  ctrl_byte       in   8   controller incoming_byte
//  ctrl_block_done in   1   controller finished_block (level; done on 0->1)
// BEHAVIOUR
//  Reset: state IDLE; ready=1; done=0; crc_ok=0; timeout_err=0; ctrl_execute=0;
//   ctrl_block_addr=0; rd_data=0; byte counter, CRC reg, timeout counter = 0.
//   RAM contents undefined. Reset mid-transfer aborts; no done pulse.
//  Inputs ctrl_* sampled through one flop each (controller runs on negedge);
//   byte and done events are rising edges of the flopped signals.
//  States:
//   IDLE    : ready=1. req -> latch addr, clear crc_ok/timeout_err/counters,
//             CRC=16'h0000, ctrl_execute=1, ISSUE.
//   ISSUE   : hold ctrl_execute=1 until ctrl_busy seen high, then deassert -> RECV.
//   RECV    : each byte event: RAM[cnt]<=ctrl_byte, CRC update, cnt++.
//             cnt==BLOCK_BYTES-1 on event -> CRC_HI.
//   CRC_HI  : byte event -> crc_rx[15:8]; CRC_LO.
//   CRC_LO  : byte event -> crc_rx[7:0]; WAIT_DONE.
//   WAIT_DONE: block-done event -> crc_ok<=(CRC_CHECK ? crc_rx==CRC : 1);
//             done=1 one cycle; IDLE.
//  CRC16-CCITT, poly 16'h1021, init 0, MSB first, one byte per cycle (combinational
//   8-step unroll); CRC of all-zero block = 16'h0000; of 512x8'hFF = 16'h7FA1.
//  Timeout: counter runs in ISSUE..WAIT_DONE; reaching TIMEOUT_CYCLES -> timeout_err=1,
//   crc_ok=0, done pulse, IDLE. Timeout and completion same cycle: completion wins.
//  Block-done event before CRC_LO completes: treat as short block -> crc_ok=0,
//   done pulse, IDLE. Extra byte events in WAIT_DONE ignored.
//  req while not ready: dropped. req same cycle as done: dropped (ready rises next cycle).
//  Host read port: rd_data <= RAM[rd_addr] every cycle in any state; reads during
//   RECV return stale/partial data (legal, not an error). Host write same-address
//   conflict impossible (single writer).
//  cnt is $clog2(BLOCK_BYTES)+1 bits; never wraps (state change at BLOCK_BYTES-1).
// STRUCTURE
//  Shared package sd_pkg: R/W op-code constants, CRC16 poly, BLOCK_BYTES default,
//   crc16_byte() function (also reused by a future write path).
//  One sub-module: sd_block_ram (1W1R, 8 x BLOCK_BYTES, registered read).
//  FSM, edge detectors, CRC and timeout counter live in sd_block_reader.
// TESTING
//  1 req addr=32'h10, model streams 0..255,0..255 + correct CRC -> ctrl_block_addr=32'h10,
//    done once, crc_ok=1, rd_addr=300 -> rd_data=8'd44 next cycle.
//  2 512x8'hFF with CRC 16'h7FA1 -> crc_ok=1; same data with 16'h7FA0 -> crc_ok=0.
//  3 model never asserts ctrl_block_done, TIMEOUT_CYCLES=1000 -> done at cycle 1000,
//    timeout_err=1, ready=1 afterwards.
//  4 rst asserted after byte 100 -> all outputs at reset values same cycle, no done;
//    new req completes normally.
//  5 req pulses during RECV and on done cycle -> ignored, exactly one ctrl_execute rise.
//  6 block done after 300 bytes -> done pulse, crc_ok=0, timeout_err=0.

Source files
------------

// File: rtl/sd_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sd_pkg
// Description : Shared SD-host definitions. Holds the op-code values, the
//               CRC16-CCITT polynomial, the default block size and a one-byte
//               CRC16 update function that both read and write paths use.
// Revision    : 1.0  initial release
// ============================================================================
package sd_pkg;

    localparam logic        c_op_read     = 1'b0;
    localparam logic        c_op_write    = 1'b1;
    localparam logic [15:0] c_crc16_poly  = 16'h1021;
    localparam int          c_block_bytes = 512;

    // CRC16-CCITT, MSB first, eight shift steps unrolled for one byte.
    function automatic logic [15:0] crc16_byte(input logic [15:0] crc,
                                               input logic [7:0]  data);
        logic [15:0] c;
        c = crc;
        for (int i = 7; i >= 0; i--) begin
            if (c[15] ^ data[i])
                c = {c[14:0], 1'b0} ^ c_crc16_poly;
            else
                c = {c[14:0], 1'b0};
        end
        return c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sd_block_ram.sv
`default_nettype none
// ============================================================================
// Module      : sd_block_ram
// Description : One-write one-read byte RAM holding a captured block.
//               Registered read port with 1-cycle latency.
// Ports       : clk, rst      clock / async active-high reset (read reg only)
//               wr_en/wr_addr/wr_data   write port
//               rd_addr/rd_data         registered read port
// Revision    : 1.0  initial release
// ============================================================================
module sd_block_ram #(
    parameter int DEPTH = 512
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [7:0]               wr_data,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [7:0]               rd_data
);

    logic [7:0] r_mem [DEPTH];

    // Storage is not reset; only the output register is.
    always_ff @(posedge clk) begin
        if (wr_en)
            r_mem[wr_addr] <= wr_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            rd_data <= 8'h00;
        else
            rd_data <= r_mem[rd_addr];
    end

endmodule
`default_nettype wire

// File: rtl/sd_block_reader.sv
`default_nettype none
// ============================================================================
// Module      : sd_block_reader
// Description : Issues single-block READs to the SD controller, captures the
//               data bytes into a byte RAM, checks the trailing CRC16 and
//               exposes the block through a registered random-access port.
// Ports       : req/req_addr/ready          host request handshake
//               done/crc_ok/timeout_err     completion status
//               rd_addr/rd_data             host read port (1-cycle latency)
//               ctrl_*                      SD controller interface
// Revision    : 1.0  initial release
// ============================================================================
module sd_block_reader
    import sd_pkg::*;
#(
    parameter int BLOCK_BYTES    = c_block_bytes,
    parameter int TIMEOUT_CYCLES = 2000000,
    parameter bit CRC_CHECK      = 1'b1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           req,
    input  logic [31:0]                    req_addr,
    output logic                           ready,
    output logic                           done,
    output logic                           crc_ok,
    output logic                           timeout_err,
    input  logic [$clog2(BLOCK_BYTES)-1:0] rd_addr,
    output logic [7:0]                     rd_data,
    output logic                           ctrl_execute,
    output logic                           ctrl_op_code,
    output logic [31:0]                    ctrl_block_addr,
    input  logic                           ctrl_busy,
    input  logic                           ctrl_byte_valid,
    input  logic [7:0]                     ctrl_byte,
    input  logic                           ctrl_block_done
);

    localparam int AW = $clog2(BLOCK_BYTES);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] c_last_byte = CW'(BLOCK_BYTES - 1);
    localparam logic [TW-1:0] c_tmo_last  = TW'(TIMEOUT_CYCLES - 1);

    localparam logic [2:0] c_st_idle      = 3'd0;
    localparam logic [2:0] c_st_issue     = 3'd1;
    localparam logic [2:0] c_st_recv      = 3'd2;
    localparam logic [2:0] c_st_crc_hi    = 3'd3;
    localparam logic [2:0] c_st_crc_lo    = 3'd4;
    localparam logic [2:0] c_st_wait_done = 3'd5;

    logic [2:0]    r_state;
    logic          r_busy_q, r_bv_q, r_bv_d, r_bd_q, r_bd_d;
    logic [7:0]    r_byte_q;
    logic [CW-1:0] r_cnt;
    logic [15:0]   r_crc, r_crc_rx;
    logic [TW-1:0] r_tmo;
    logic          r_done, r_crc_ok, r_tmo_err, r_exec;
    logic [31:0]   r_addr;

    logic w_byte_ev, w_blk_ev, w_active, w_tmo_hit, w_ram_we, w_short;

    // The controller drives on negedge; one flop per input re-times it and a
    // second stage on the strobes turns the levels into rising-edge events.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy_q <= 1'b0;
            r_bv_q   <= 1'b0;
            r_bv_d   <= 1'b0;
            r_bd_q   <= 1'b0;
            r_bd_d   <= 1'b0;
            r_byte_q <= 8'h00;
        end else begin
            r_busy_q <= ctrl_busy;
            r_bv_q   <= ctrl_byte_valid;
            r_bv_d   <= r_bv_q;
            r_bd_q   <= ctrl_block_done;
            r_bd_d   <= r_bd_q;
            r_byte_q <= ctrl_byte;
        end
    end

    assign w_byte_ev = r_bv_q & ~r_bv_d;
    assign w_blk_ev  = r_bd_q & ~r_bd_d;
    assign w_active  = (r_state != c_st_idle);
    assign w_tmo_hit = w_active && (r_tmo == c_tmo_last);
    assign w_ram_we  = (r_state == c_st_recv) && w_byte_ev;
    // Block finished before the CRC trailer was fully received.
    assign w_short   = w_blk_ev && w_active && (r_state != c_st_wait_done);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= c_st_idle;
            r_cnt     <= '0;
            r_crc     <= 16'h0000;
            r_crc_rx  <= 16'h0000;
            r_tmo     <= '0;
            r_done    <= 1'b0;
            r_crc_ok  <= 1'b0;
            r_tmo_err <= 1'b0;
            r_exec    <= 1'b0;
            r_addr    <= 32'h0;
        end else begin
            r_done <= 1'b0;
            if (w_active)
                r_tmo <= r_tmo + TW'(1);

            case (r_state)
                c_st_idle: begin
                    // Gating on r_done drops a req that lands on the done cycle.
                    if (req && !r_done) begin
                        r_addr    <= req_addr;
                        r_crc_ok  <= 1'b0;
                        r_tmo_err <= 1'b0;
                        r_cnt     <= '0;
                        r_crc     <= 16'h0000;
                        r_crc_rx  <= 16'h0000;
                        r_tmo     <= '0;
                        r_exec    <= 1'b1;
                        r_state   <= c_st_issue;
                    end
                end
                c_st_issue: begin
                    if (r_busy_q) begin
                        r_exec  <= 1'b0;
                        r_state <= c_st_recv;
                    end
                end
                c_st_recv: begin
                    if (w_byte_ev) begin
                        r_crc <= crc16_byte(r_crc, r_byte_q);
                        r_cnt <= r_cnt + CW'(1);
                        if (r_cnt == c_last_byte)
                            r_state <= c_st_crc_hi;
                    end
                end
                c_st_crc_hi: begin
                    if (w_byte_ev) begin
                        r_crc_rx[15:8] <= r_byte_q;
                        r_state        <= c_st_crc_lo;
                    end
                end
                c_st_crc_lo: begin
                    if (w_byte_ev) begin
                        r_crc_rx[7:0] <= r_byte_q;
                        r_state       <= c_st_wait_done;
                    end
                end
                c_st_wait_done: begin
                    if (w_blk_ev) begin
                        r_crc_ok <= CRC_CHECK ? (r_crc_rx == r_crc) : 1'b1;
                        r_done   <= 1'b1;
                        r_state  <= c_st_idle;
                    end
                end
                default: r_state <= c_st_idle;
            endcase

            // Any block-done event (short or complete) outranks the timeout.
            if (w_short) begin
                r_crc_ok <= 1'b0;
                r_done   <= 1'b1;
                r_exec   <= 1'b0;
                r_state  <= c_st_idle;
            end else if (w_tmo_hit && !w_blk_ev) begin
                r_tmo_err <= 1'b1;
                r_crc_ok  <= 1'b0;
                r_done    <= 1'b1;
                r_exec    <= 1'b0;
                r_state   <= c_st_idle;
            end
        end
    end

    sd_block_ram #(
        .DEPTH (BLOCK_BYTES)
    ) u_ram (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (w_ram_we),
        .wr_addr (r_cnt[AW-1:0]),
        .wr_data (r_byte_q),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    assign ready           = (r_state == c_st_idle) && !r_done;
    assign done            = r_done;
    assign crc_ok          = r_crc_ok;
    assign timeout_err     = r_tmo_err;
    assign ctrl_execute    = r_exec;
    assign ctrl_op_code    = c_op_read;
    assign ctrl_block_addr = r_addr;

endmodule
`default_nettype wire

// File: tb/tb_sd_block_reader.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_sd_block_reader
// Description : Self-checking bench for sd_block_reader. A table of block
//               transactions drives a negedge controller model; expected CRCs
//               and RAM contents come from a bit-serial reference model.
// Revision    : 1.0  initial release
// ============================================================================
module tb_sd_block_reader;

    localparam int c_bytes = 512;
    localparam int c_tmo   = 3000;

    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic [31:0] req_addr;
    logic        ready, done, crc_ok, timeout_err;
    logic [8:0]  rd_addr;
    logic [7:0]  rd_data;
    logic        ctrl_execute, ctrl_op_code;
    logic [31:0] ctrl_block_addr;
    logic        ctrl_busy, ctrl_byte_valid, ctrl_block_done;
    logic [7:0]  ctrl_byte;

    always #5 clk = ~clk;

    sd_block_reader #(
        .BLOCK_BYTES    (c_bytes),
        .TIMEOUT_CYCLES (c_tmo),
        .CRC_CHECK      (1'b1)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .req             (req),
        .req_addr        (req_addr),
        .ready           (ready),
        .done            (done),
        .crc_ok          (crc_ok),
        .timeout_err     (timeout_err),
        .rd_addr         (rd_addr),
        .rd_data         (rd_data),
        .ctrl_execute    (ctrl_execute),
        .ctrl_op_code    (ctrl_op_code),
        .ctrl_block_addr (ctrl_block_addr),
        .ctrl_busy       (ctrl_busy),
        .ctrl_byte_valid (ctrl_byte_valid),
        .ctrl_byte       (ctrl_byte),
        .ctrl_block_done (ctrl_block_done)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int done_cnt = 0;
    int exe_rises = 0;
    logic exe_prev = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (done === 1'b1) done_cnt <= done_cnt + 1;
        if (ctrl_execute === 1'b1 && exe_prev !== 1'b1) exe_rises <= exe_rises + 1;
        exe_prev <= ctrl_execute;
    end

    typedef struct {
        logic [31:0] addr;
        int          pat;       // 0 ramp, 1 all FF, 2 random, 3 zeros
        int          nb;        // data bytes streamed (CRC only sent when full)
        bit          fix;       // send crc_val verbatim instead of model CRC
        logic [15:0] crc_val;
        logic [15:0] crc_xor;   // corruption applied to the model CRC
        bit          blk_done;
        bit          extra_req;
        bit          exp_ok;
        bit          exp_tmo;
    } vec_t;

    logic [7:0] blk [c_bytes];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference CRC: treat the block as one long bit string and divide by the
    // CCITT polynomial one bit at a time.
    function automatic logic [15:0] model_crc();
        bit q[$];
        logic [15:0] r;
        for (int i = 0; i < c_bytes; i++)
            for (int b = 7; b >= 0; b--)
                q.push_back(blk[i][b]);
        r = 16'h0000;
        foreach (q[k]) begin
            bit top;
            top = r[15];
            r = r << 1;
            if (top ^ q[k]) r = r ^ 16'h1021;
        end
        return r;
    endfunction

    task automatic send_byte(input logic [7:0] b);
        ctrl_byte       = b;
        ctrl_byte_valid = 1'b1;
        @(negedge clk);
        ctrl_byte_valid = 1'b0;
        repeat (1 + $urandom_range(0, 1)) @(negedge clk);
    endtask

    // Presents req for one cycle and checks the controller handshake start.
    task automatic issue(input logic [31:0] a, output int t_acc);
        int k;
        k = 0;
        while (ready !== 1'b1 && k < 50) begin @(negedge clk); k++; end
        check("ready_before_req", ready, 1);
        req = 1'b1; req_addr = a;
        @(negedge clk);
        req = 1'b0; req_addr = $urandom;
        t_acc = cyc;
        check("exec_after_req", ctrl_execute, 1);
        check("ctrl_block_addr", ctrl_block_addr, a);
        check("op_code_read", ctrl_op_code, 0);
        ctrl_busy = 1'b1;
        k = 0;
        while (ctrl_execute !== 1'b0 && k < 10) begin @(negedge clk); k++; end
        check("exec_drop_on_busy", ctrl_execute, 0);
    endtask

    task automatic run_vec(input vec_t v);
        int t_acc, k, d0, e0, a;
        logic [15:0] crc_tx;
        d0 = done_cnt; e0 = exe_rises;
        for (int i = 0; i < c_bytes; i++)
            case (v.pat)
                0: blk[i] = 8'(i % 256);
                1: blk[i] = 8'hFF;
                2: blk[i] = 8'($urandom);
                default: blk[i] = 8'h00;
            endcase
        crc_tx = v.fix ? v.crc_val : (model_crc() ^ v.crc_xor);
        issue(v.addr, t_acc);
        for (int i = 0; i < v.nb; i++) begin
            if (v.extra_req && i == 50) begin req = 1'b1; req_addr = ~v.addr; end
            send_byte(blk[i]);
            if (v.extra_req && i == 50) req = 1'b0;
        end
        if (v.nb == c_bytes) begin
            send_byte(crc_tx[15:8]);
            send_byte(crc_tx[7:0]);
        end
        if (v.blk_done) begin
            ctrl_block_done = 1'b1;
            @(negedge clk);
            @(negedge clk);
            ctrl_block_done = 1'b0;
            ctrl_busy = 1'b0;
        end
        k = 0;
        while (done !== 1'b1 && k < c_tmo + 100) begin @(negedge clk); k++; end
        check("done_seen", done, 1);
        check("crc_ok", crc_ok, v.exp_ok);
        check("timeout_err", timeout_err, v.exp_tmo);
        if (v.exp_tmo) check("timeout_latency", cyc - t_acc, c_tmo);
        if (v.extra_req) begin req = 1'b1; req_addr = ~v.addr; end
        @(negedge clk);
        req = 1'b0;
        ctrl_busy = 1'b0;
        check("done_is_pulse", done, 0);
        check("ready_after_done", ready, 1);
        check("crc_ok_held", crc_ok, v.exp_ok);
        check("addr_kept", ctrl_block_addr, v.addr);
        if (v.nb > 0) begin
            for (int r = 0; r < 4; r++) begin
                a = (v.pat == 0 && r == 0 && v.nb > 300) ? 300 : $urandom_range(0, v.nb - 1);
                rd_addr = 9'(a);
                @(negedge clk);
                check("rd_data", rd_data, blk[a]);
            end
        end
        @(negedge clk);
        check("exec_idle", ctrl_execute, 0);
        check("one_done_pulse", done_cnt - d0, 1);
        check("one_exec_rise", exe_rises - e0, 1);
    endtask

    vec_t vecs [10];

    initial begin
        int d0, t_acc;
        vecs[0] = '{32'h10,       0, c_bytes, 0, 16'h0,    16'h0,    1, 0, 1, 0};
        vecs[1] = '{32'h20,       1, c_bytes, 1, 16'h7FA1, 16'h0,    1, 0, 1, 0};
        vecs[2] = '{32'h21,       1, c_bytes, 1, 16'h7FA0, 16'h0,    1, 0, 0, 0};
        vecs[3] = '{32'h30,       3, c_bytes, 1, 16'h0000, 16'h0,    1, 0, 1, 0};
        vecs[4] = '{32'hDEADBEEF, 2, c_bytes, 0, 16'h0,    16'h0,    1, 0, 1, 0};
        vecs[5] = '{32'h40,       2, c_bytes, 0, 16'h0,    16'h8000, 1, 0, 0, 0};
        vecs[6] = '{32'h50,       2, 300,     0, 16'h0,    16'h0,    1, 0, 0, 0};
        vecs[7] = '{32'h60,       2, 0,       0, 16'h0,    16'h0,    0, 0, 0, 1};
        vecs[8] = '{32'h70,       0, c_bytes, 0, 16'h0,    16'h0,    1, 1, 1, 0};
        vecs[9] = '{32'h80,       2, c_bytes, 0, 16'h0,    16'h0,    1, 0, 1, 0};

        rst = 1'b1; req = 1'b0; req_addr = 32'h0; rd_addr = 9'd0;
        ctrl_busy = 1'b0; ctrl_byte_valid = 1'b0; ctrl_byte = 8'h00; ctrl_block_done = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ready", ready, 1);
        check("rst_done", done, 0);
        check("rst_crc_ok", crc_ok, 0);
        check("rst_timeout", timeout_err, 0);
        check("rst_exec", ctrl_execute, 0);
        check("rst_blk_addr", ctrl_block_addr, 0);
        check("rst_rd_data", rd_data, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        foreach (vecs[i]) run_vec(vecs[i]);

        // Random blocks with random corruption; expectation from the model.
        for (int n = 0; n < 3; n++) begin
            vec_t v;
            v = '{$urandom, 2, c_bytes, 0, 16'h0, 16'h0, 1, 0, 1, 0};
            v.crc_xor = ($urandom_range(0, 1) == 1) ? 16'(1 << $urandom_range(0, 15)) : 16'h0;
            v.exp_ok  = (v.crc_xor == 16'h0);
            run_vec(v);
        end

        // Reset part-way through a transfer.
        d0 = done_cnt;
        for (int i = 0; i < c_bytes; i++) blk[i] = 8'($urandom);
        issue(32'h99, t_acc);
        for (int i = 0; i < 100; i++) send_byte(blk[i]);
        rst = 1'b1;
        #1;
        check("mid_rst_ready", ready, 1);
        check("mid_rst_done", done, 0);
        check("mid_rst_exec", ctrl_execute, 0);
        check("mid_rst_blk_addr", ctrl_block_addr, 0);
        check("mid_rst_rd_data", rd_data, 0);
        check("mid_rst_crc_ok", crc_ok, 0);
        @(negedge clk);
        ctrl_busy = 1'b0; ctrl_byte_valid = 1'b0;
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check("mid_rst_no_done", done_cnt - d0, 0);
        run_vec(vecs[0]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish, got %0d compares expected completion", n_cmp);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
